mult_dot_issuer: RTL and testbench



---
 rtl/tmvp_pkg.sv | 17 +
 rtl/mult_dot_issuer_if.sv | 39 +++
 rtl/mult_dot_issuer.sv | 113 +++++++++++
 tb/tb_mult_dot_issuer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmvp_pkg.sv
// Shared types and constants for the TMVP SIMD lane: issuer FSM states and operand/product widths.
package tmvp_pkg;

  localparam int DEF_INT_SIZE = 16;
  localparam int DEF_LEN_W    = 8;
  localparam int PROD_W       = 2 * DEF_INT_SIZE;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_OUTPUT    = 3'd5
  } state_t;

endpackage

// File: rtl/mult_dot_issuer_if.sv
// Bundle of the issuer's control, operand stream, mult start/busy/done and result stream signals.
// master = the issuer itself, slave = its surroundings (sequencer, mult, result consumer).
interface mult_dot_issuer_if
  import tmvp_pkg::*;
#(
  parameter int INT_SIZE = DEF_INT_SIZE,
  parameter int LEN_W    = DEF_LEN_W
);

  localparam int PW = 2 * INT_SIZE;

  logic                go;
  logic [LEN_W-1:0]    cfg_len;
  logic                op_valid;
  logic                op_ready;
  logic [INT_SIZE-1:0] op_a;
  logic [INT_SIZE-1:0] op_b;
  logic                mul_start;
  logic [PW-1:0]       mul_a;
  logic [PW-1:0]       mul_b;
  logic [PW-1:0]       mul_result;
  logic                mul_busy;
  logic                mul_done;
  logic                res_valid;
  logic                res_ready;
  logic [PW-1:0]       res_data;
  logic                busy;

  modport master (
    input  go, cfg_len, op_valid, op_a, op_b, mul_result, mul_busy, mul_done, res_ready,
    output op_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy
  );

  modport slave (
    output go, cfg_len, op_valid, op_a, op_b, mul_result, mul_busy, mul_done, res_ready,
    input  op_ready, mul_start, mul_a, mul_b, res_valid, res_data, busy
  );

endinterface

// File: rtl/mult_dot_issuer.sv
// Issues operand pairs to a single-cycle mult and accumulates an N-element dot product.
// 4 cycles per element, result 4N+1 cycles after go; stalls in FETCH on op_valid and in OUTPUT on res_ready.
module mult_dot_issuer
  import tmvp_pkg::*;
#(
  parameter int INT_SIZE = DEF_INT_SIZE,
  parameter int LEN_W    = DEF_LEN_W
)(
  input  logic                clk,
  input  logic                rst,
  mult_dot_issuer_if.master   bus
);

  localparam int PW = 2 * INT_SIZE;

  state_t           r_state;
  logic [PW-1:0]    r_acc;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len;
  logic [PW-1:0]    r_mul_a;
  logic [PW-1:0]    r_mul_b;
  logic             r_mul_start;
  logic             r_res_valid;
  logic             r_busy;

  logic [LEN_W-1:0] w_count_nxt;
  logic             w_prod_rdy;

  assign w_count_nxt = r_count + LEN_W'(1);
  // mult idles with done=1, so a product is only trusted once busy has dropped again.
  assign w_prod_rdy  = bus.mul_done && !bus.mul_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.go) begin
            r_len   <= bus.cfg_len;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (bus.cfg_len == '0) begin
              r_state     <= S_OUTPUT;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.op_valid) begin
            r_mul_a     <= PW'(bus.op_a);
            r_mul_b     <= PW'(bus.op_b);
            r_mul_start <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.mul_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (w_prod_rdy) begin
            r_acc   <= r_acc + bus.mul_result;
            r_count <= w_count_nxt;
            if (w_count_nxt == r_len) begin
              r_state     <= S_OUTPUT;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        S_OUTPUT: begin
          if (bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready  = (r_state == S_FETCH);
  assign bus.mul_start = r_mul_start;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_acc;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mult_dot_issuer.sv
// Directed bench for mult_dot_issuer with a behavioural single-cycle mult responder.
module tb_mult_dot_issuer;

  localparam int IS = 16;
  localparam int LW = 8;
  localparam int PW = 2 * IS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mult_dot_issuer_if #(.INT_SIZE(IS), .LEN_W(LW)) bus();

  mult_dot_issuer #(.INT_SIZE(IS), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // single-cycle mult: busy for the cycle after start, then done with the product held
  always @(posedge clk) begin
    if (!rst) begin
      bus.mul_busy   <= 1'b0;
      bus.mul_done   <= 1'b1;
      bus.mul_result <= '0;
    end else if (bus.mul_start === 1'b1) begin
      bus.mul_busy   <= 1'b1;
      bus.mul_done   <= 1'b0;
      bus.mul_result <= PW'(bus.mul_a * bus.mul_b);
    end else if (bus.mul_busy === 1'b1) begin
      bus.mul_busy <= 1'b0;
      bus.mul_done <= 1'b1;
    end
  end

  // operand feeder: offers pair fidx after feed_gap cycles of FETCH with op_valid low
  logic [IS-1:0] fa [8];
  logic [IS-1:0] fb [8];
  int feed_n = 0, feed_gap = 0, fidx = 0, gap_cnt = 0, n_stall = 0;
  bit pend = 1'b0;

  always @(negedge clk) begin
    if (pend) begin
      fidx++;
      gap_cnt = 0;
      pend    = 1'b0;
    end
    if (fidx < feed_n && gap_cnt >= feed_gap) begin
      bus.op_valid = 1'b1;
      bus.op_a     = fa[fidx];
      bus.op_b     = fb[fidx];
    end else begin
      bus.op_valid = 1'b0;
      if (bus.op_ready === 1'b1) gap_cnt++;
    end
    if (bus.op_ready === 1'b1 && bus.op_valid !== 1'b1) n_stall++;
    pend = (bus.op_valid === 1'b1 && bus.op_ready === 1'b1);
  end

  int n_start = 0, n_ready = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (bus.mul_start === 1'b1) n_start++;
    if (bus.op_ready === 1'b1) n_ready++;
    if (bus.mul_start === 1'b1 && bus.op_ready === 1'b1) n_overlap++;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_pair(input int i, input logic [IS-1:0] a, input logic [IS-1:0] b);
    fa[i] = a;
    fb[i] = b;
  endtask

  task automatic load(input int n, input int gap);
    feed_n   = n;
    feed_gap = gap;
    fidx     = 0;
    gap_cnt  = 0;
    pend     = 1'b0;
  endtask

  task automatic start_run(input int len);
    @(negedge clk);
    bus.go      = 1'b1;
    bus.cfg_len = LW'(len);
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.go = 1'b0;
      cyc++;
    end while (bus.res_valid !== 1'b1 && cyc < 400);
    if (bus.res_valid !== 1'b1) chk("res_timeout", 64'd0, 64'd1);
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_mul_start"}, 64'(bus.mul_start), 64'd0);
    chk({pfx, "_op_ready"},  64'(bus.op_ready),  64'd0);
    chk({pfx, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    chk({pfx, "_busy"},      64'(bus.busy),      64'd0);
    chk({pfx, "_mul_a"},     64'(bus.mul_a),     64'd0);
    chk({pfx, "_mul_b"},     64'(bus.mul_b),     64'd0);
    chk({pfx, "_res_data"},  64'(bus.res_data),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cyc2, bad;
    bus.go        = 1'b0;
    bus.cfg_len   = '0;
    bus.res_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    rst = 1'b1;

    // len=3: 2*3 + 4*5 + 6*7 = 68
    set_pair(0, 16'd2, 16'd3);
    set_pair(1, 16'd4, 16'd5);
    set_pair(2, 16'd6, 16'd7);
    load(3, 0);
    n_start = 0;
    start_run(3);
    wait_res(cyc);
    chk("t1_latency", 64'(cyc), 64'd13);
    chk("t1_data", 64'(bus.res_data), 64'd68);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("t1_starts", 64'(n_start), 64'd3);
    chk("t1_valid_drop", 64'(bus.res_valid), 64'd0);
    chk("t1_idle_busy", 64'(bus.busy), 64'd0);

    // wraparound: 2 * 0xFFFE0001 = 0x1FFFC0002
    set_pair(0, 16'hFFFF, 16'hFFFF);
    set_pair(1, 16'hFFFF, 16'hFFFF);
    load(2, 0);
    start_run(2);
    wait_res(cyc);
    chk("t2_latency", 64'(cyc), 64'd9);
    chk("t2_data", 64'(bus.res_data), 64'h0000_0000_FFFC_0002);

    // len=0: immediate zero result, nothing fetched or issued
    @(negedge clk);
    n_start = 0;
    n_ready = 0;
    start_run(0);
    wait_res(cyc);
    chk("t3_latency", 64'(cyc), 64'd1);
    chk("t3_data", 64'(bus.res_data), 64'd0);
    @(negedge clk);
    chk("t3_starts", 64'(n_start), 64'd0);
    chk("t3_ready_seen", 64'(n_ready), 64'd0);

    // operand stalls and result backpressure: 1*2 + 3*4 = 14
    bus.res_ready = 1'b0;
    set_pair(0, 16'd1, 16'd2);
    set_pair(1, 16'd3, 16'd4);
    load(2, 5);
    n_stall   = 0;
    n_overlap = 0;
    start_run(2);
    wait_res(cyc);
    chk("t4_latency", 64'(cyc), 64'd19);
    chk("t4_data", 64'(bus.res_data), 64'd14);
    chk("t4_stall_cycles", 64'(n_stall), 64'd10);
    chk("t4_start_in_fetch", 64'(n_overlap), 64'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd14) bad++;
    end
    chk("t4_hold", 64'(bad), 64'd0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_drop", 64'(bus.res_valid), 64'd0);
    chk("t4_idle_busy", 64'(bus.busy), 64'd0);

    // go during WAIT_DONE ignored: 5*5 + 2*10 = 45
    bus.res_ready = 1'b0;
    set_pair(0, 16'd5, 16'd5);
    set_pair(1, 16'd2, 16'd10);
    load(2, 0);
    start_run(2);
    @(negedge clk);
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    bus.go      = 1'b1;
    bus.cfg_len = LW'(7);
    wait_res(cyc2);
    chk("t5_latency", 64'(cyc2 + 4), 64'd9);
    chk("t5_data", 64'(bus.res_data), 64'd45);
    @(negedge clk);
    chk("t5_busy_hold", 64'(bus.busy), 64'd1);
    chk("t5_data_hold", 64'(bus.res_data), 64'd45);
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("t5_idle_busy", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5_no_restart", 64'(bus.busy), 64'd0);

    // reset in WAIT_DONE of a len=4 run, then a clean len=1 run
    set_pair(0, 16'd7, 16'd7);
    set_pair(1, 16'd7, 16'd7);
    set_pair(2, 16'd7, 16'd7);
    set_pair(3, 16'd7, 16'd7);
    load(4, 0);
    start_run(4);
    @(negedge clk);
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_idle_outputs("t6_rst");
    set_pair(0, 16'd3, 16'd3);
    load(1, 0);
    start_run(1);
    wait_res(cyc);
    chk("t6_latency", 64'(cyc), 64'd5);
    chk("t6_data", 64'(bus.res_data), 64'd9);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
